// File: rtl/cpu.sv
// Program-1 fixed-function core: reciprocal q = floor(32768 / d) of a 16-bit divisor
// held big-endian in DM1.Core, result written back big-endian, completion flagged on Ack.

module cpu_dm #(
  parameter int unsigned DM_DEPTH = 256,
  parameter int unsigned AW       = 8
) (
  input  logic          Clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_a_o,
  output logic [7:0]    rdata_b_o
);

  // Contents survive reset; the host preloads operands hierarchically.
  logic [7:0] Core [0:DM_DEPTH-1];

  always_ff @(posedge Clk) begin
    if (we_i) Core[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = Core[raddr_a_i];
  assign rdata_b_o = Core[raddr_b_i];

endmodule

module cpu #(
  parameter int unsigned DM_DEPTH = 256,
  parameter int unsigned DIV_ADDR = 8,
  parameter int unsigned RES_ADDR = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  localparam int unsigned AW = $clog2(DM_DEPTH);
  localparam logic [AW-1:0] DIV_HI_A = AW'(DIV_ADDR);
  localparam logic [AW-1:0] DIV_LO_A = AW'(DIV_ADDR + 1);
  localparam logic [AW-1:0] RES_HI_A = AW'(RES_ADDR);
  localparam logic [AW-1:0] RES_LO_A = AW'(RES_ADDR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_STORE_HI,
    S_STORE_LO,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        start_prev_q;
  logic        ack_q;
  logic [15:0] div_q, div_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] quo_q, quo_d;
  logic [16:0] rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [16:0] rem_sh;
  logic [15:0] result;
  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [7:0]  div_hi, div_lo;

  cpu_dm #(
    .DM_DEPTH(DM_DEPTH),
    .AW      (AW)
  ) DM1 (
    .Clk      (Clk),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .raddr_a_i(DIV_HI_A),
    .raddr_b_i(DIV_LO_A),
    .rdata_a_o(div_hi),
    .rdata_b_o(div_lo)
  );

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      ack_q        <= 1'b0;
      div_q        <= '0;
      dvd_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= Start;
      // Ack is registered so it lands one edge after the final store and drops with DONE's exit.
      ack_q        <= (state_q == S_DONE) && (state_d == S_DONE);
      div_q        <= div_d;
      dvd_q        <= dvd_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start_prev_q && !Start) state_d = S_LOAD;
      S_LOAD:     state_d = S_DIV;
      S_DIV:      if (cnt_q == 4'd15) state_d = S_STORE_HI;
      S_STORE_HI: state_d = S_STORE_LO;
      S_STORE_LO: state_d = S_DONE;
      S_DONE:     if (Start) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Restoring division: shift in next dividend bit, subtract divisor when it fits.
  assign rem_sh = {rem_q[15:0], dvd_q[15]};

  always_comb begin
    div_d = div_q;
    dvd_d = dvd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_LOAD: begin
        div_d = {div_hi, div_lo};
        dvd_d = 16'h8000;
        quo_d = '0;
        rem_d = '0;
        cnt_d = '0;
      end
      S_DIV: begin
        dvd_d = {dvd_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (rem_sh >= {1'b0, div_q}) begin
          rem_d = rem_sh - {1'b0, div_q};
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[14:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Divide-by-zero yields the 0x0001 sentinel; the loop still runs for fixed latency.
  assign result = (div_q == '0) ? 16'h0001 : quo_q;

  // Output logic
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = RES_HI_A;
    mem_wdata = result[15:8];
    unique case (state_q)
      S_STORE_HI: begin
        mem_we    = 1'b1;
        mem_waddr = RES_HI_A;
        mem_wdata = result[15:8];
      end
      S_STORE_LO: begin
        mem_we    = 1'b1;
        mem_waddr = RES_LO_A;
        mem_wdata = result[7:0];
      end
      default: ;
    endcase
  end

  assign Ack = ack_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed and random divisors against a reciprocal reference.

module tb_cpu;

  logic Clk;
  logic Reset;
  logic Start;
  logic Ack;

  int unsigned n_checks;
  int unsigned n_errors;

  cpu #(
    .DM_DEPTH(256),
    .DIV_ADDR(8),
    .RES_ADDR(10)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Start(Start),
    .Ack  (Ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_recip(input logic [15:0] d);
    int unsigned num;
    num = 32768;
    if (d == 16'd0) return 16'h0001;
    return 16'(num / int'(d));
  endfunction

  task automatic load_divisor(input logic [15:0] d);
    dut.DM1.Core[8]  = d[15:8];
    dut.DM1.Core[9]  = d[7:0];
    dut.DM1.Core[10] = 8'hAA;
    dut.DM1.Core[11] = 8'h55;
  endtask

  // Full program run: load while Start high, launch, check Ack timing, result, and Ack drop.
  task automatic run_prog(input string tag, input logic [15:0] d, input bit glitch_start);
    logic [15:0] exp;
    logic [15:0] got;
    exp = ref_recip(d);
    @(negedge Clk);
    Start = 1'b1;
    load_divisor(d);
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk);
      #1;
      if (glitch_start && k == 5) Start = 1'b1;
      if (glitch_start && k == 7) Start = 1'b0;
      if (k == 19) check_eq({tag, ".ack_early"}, 32'(Ack), 32'd0);
      if (k == 20) check_eq({tag, ".ack_at20"}, 32'(Ack), 32'd1);
    end
    got = {dut.DM1.Core[10], dut.DM1.Core[11]};
    check_eq({tag, ".result"}, 32'(got), 32'(exp));
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check_eq({tag, ".ack_drop"}, 32'(Ack), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b0;
    Start = 1'b1;
    load_divisor(16'h0004);
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset.ack", 32'(Ack), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Start held high: core must stay idle and leave the result bytes alone.
    repeat (30) @(posedge Clk);
    #1;
    check_eq("hold.ack", 32'(Ack), 32'd0);
    check_eq("hold.core10", 32'(dut.DM1.Core[10]), 32'hAA);

    run_prog("d4",    16'h0004, 1'b0);
    run_prog("d36",   16'h0024, 1'b0);
    run_prog("d1",    16'h0001, 1'b0);
    run_prog("d3",    16'h0003, 1'b0);
    run_prog("dFFFF", 16'hFFFF, 1'b0);
    run_prog("d8000", 16'h8000, 1'b0);
    run_prog("d0",    16'h0000, 1'b0);
    run_prog("glitch", 16'h0024, 1'b1);

    // Reset during DIV: abort, no stores, then recover with a fresh run.
    @(negedge Clk);
    Start = 1'b1;
    load_divisor(16'h0009);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_eq("abort.ack", 32'(Ack), 32'd0);
    repeat (25) @(posedge Clk);
    #1;
    check_eq("abort.ack_held", 32'(Ack), 32'd0);
    check_eq("abort.core", 32'({dut.DM1.Core[10], dut.DM1.Core[11]}), 32'hAA55);
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    run_prog("d7", 16'h0007, 1'b0);

    run_prog("d0100", 16'h0100, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] rd;
      rd = 16'($urandom_range(0, 65535));
      if (i < 5) rd = 16'($urandom_range(1, 300));
      run_prog($sformatf("rand%0d", i), rd, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
